// File: rtl/nibble_serial_adder_ctrl_if.sv
// nibble_serial_adder_ctrl_if
//
// Bundles the operand/result handshakes of nibble_serial_adder_ctrl.
//
// Handshake rule for both channels: a transfer happens on a rising clk edge
// where valid && ready are both high. The producer holds its data
// stable while valid is high and ready is low. valid never waits on ready.
//
// Signals:
//   in_valid, A, B, Cin, (Sub) : operand channel, producer = master
//   in_ready                   : operand channel, consumer = slave
//   out_valid, S, Cout         : result channel, producer = slave
//   out_ready                  : result channel, consumer = master
//   busy                       : slave is in RUN or DONE
//   fsm_state                  : slave controller state, for observation
//
// Optional macro: SUB_EN adds the Sub (subtract select) signal.
interface nibble_serial_adder_ctrl_if #(
    parameter int N_NIBBLES = 4
);
    localparam int W = 4 * N_NIBBLES;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Cin;
`ifdef SUB_EN
    logic         Sub;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] S;
    logic         Cout;
    logic         busy;
    logic [1:0]   fsm_state;

    modport master (
        output in_valid,
        output A,
        output B,
        output Cin,
`ifdef SUB_EN
        output Sub,
`endif
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  S,
        input  Cout,
        input  busy,
        input  fsm_state
    );

    modport slave (
        input  in_valid,
        input  A,
        input  B,
        input  Cin,
`ifdef SUB_EN
        input  Sub,
`endif
        input  out_ready,
        output in_ready,
        output out_valid,
        output S,
        output Cout,
        output busy,
        output fsm_state
    );
endinterface

// File: rtl/nibble_serial_adder_ctrl.sv
// nibble_serial_adder_ctrl
//
// Wide adder (W = 4*N_NIBBLES bits) built from one 4-bit ripple adder that
// is reused once per clock, least-significant nibble first. The ripple carry
// between nibbles lives in carry_q.
//
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous, active-high reset
//   bus  : nibble_serial_adder_ctrl_if.slave
//          operands in (in_valid/in_ready, A, B, Cin, Sub with SUB_EN),
//          result out (out_valid/out_ready, S, Cout), busy, fsm_state
//
// Optional macro: SUB_EN. When defined, Sub=1 at accept loads ~B and a
// carry of 1, giving A-B mod 2^W with Cout=1 meaning "no borrow".
//
// Timing: accept on edge 0, nibble k computed on edge k+1, out_valid high
// after edge N_NIBBLES. Result held until out_valid && out_ready.

// 4-bit ripple-carry adder: {Cout, Sum} = A + B + Cin.
module fourBitadder (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] Sum,
    output logic       Cout
);
    logic [4:0] c;

    assign c[0] = Cin;

    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign Sum[i]   = A[i] ^ B[i] ^ c[i];
        assign c[i + 1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
    end

    assign Cout = c[4];
endmodule

module nibble_serial_adder_ctrl #(
    parameter int N_NIBBLES = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    nibble_serial_adder_ctrl_if.slave    bus
);
    localparam int W  = 4 * N_NIBBLES;
    localparam int IW = (N_NIBBLES > 1) ? $clog2(N_NIBBLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nx;

    // Operands and sum viewed as nibble arrays so idx selects a nibble.
    logic [N_NIBBLES-1:0][3:0] a_q;
    logic [N_NIBBLES-1:0][3:0] b_q;
    logic [N_NIBBLES-1:0][3:0] s_q;
    logic                      carry_q;
    logic [IW-1:0]             idx;

    logic         accept;
    logic         last_nib;
    logic [3:0]   nib_sum;
    logic         nib_cout;
    logic [W-1:0] b_load;
    logic         c_load;

    assign accept   = (state == IDLE) && bus.in_valid;
    assign last_nib = (idx == IW'(N_NIBBLES - 1));

    // Subtraction is A + ~B + 1; the inversion and forced carry are applied
    // once at load time so the RUN datapath stays add-only.
`ifdef SUB_EN
    assign b_load = bus.Sub ? ~bus.B : bus.B;
    assign c_load = bus.Sub ? 1'b1   : bus.Cin;
`else
    assign b_load = bus.B;
    assign c_load = bus.Cin;
`endif

    fourBitadder u_adder (
        .A    (a_q[idx]),
        .B    (b_q[idx]),
        .Cin  (carry_q),
        .Sum  (nib_sum),
        .Cout (nib_cout)
    );

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.in_valid)  state_nx = RUN;
            RUN:     if (last_nib)      state_nx = DONE;
            DONE:    if (bus.out_ready) state_nx = IDLE;
            default:                    state_nx = IDLE;
        endcase
    end

    // State register and datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            idx     <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_q     <= bus.A;
                        b_q     <= b_load;
                        carry_q <= c_load;
                        s_q     <= '0;
                        idx     <= '0;
                    end
                end
                RUN: begin
                    s_q[idx] <= nib_sum;
                    carry_q  <= nib_cout;
                    // idx stops on the top nibble rather than wrapping.
                    if (!last_nib) begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // in_ready is gated by rst so it reads low during reset.
    assign bus.in_ready  = (state == IDLE) && !rst;
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state == RUN) || (state == DONE);
    assign bus.S         = s_q;
    assign bus.Cout      = carry_q;
    assign bus.fsm_state = state;
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// tb_nibble_serial_adder_ctrl
//
// Directed bench for nibble_serial_adder_ctrl with N_NIBBLES=4 (16-bit).
// Expected sums are hand-computed constants queued in exp_q.
module tb_nibble_serial_adder_ctrl;
    localparam int N = 4;
    localparam int W = 4 * N;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    nibble_serial_adder_ctrl_if #(.N_NIBBLES(N)) bus ();

    nibble_serial_adder_ctrl #(.N_NIBBLES(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic [W:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Present operands in IDLE; returns #1 after the accept edge.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic sub, input logic [W-1:0] exp_s, input logic exp_c);
        int guard;
        guard = 0;
        while (!bus.in_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        check("in_ready_before_send", 32'(bus.in_ready), 32'd1);
        bus.A        = a;
        bus.B        = b;
        bus.Cin      = cin;
`ifdef SUB_EN
        bus.Sub      = sub;
`else
        if (sub) $display("note: sub ignored without SUB_EN");
`endif
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        exp_q.push_back({exp_c, exp_s});
    endtask

    // Wait for out_valid (expecting it after exp_lat more edges), check the
    // result, optionally stall hold cycles, then complete the handshake.
    task automatic recv(input string tag, input int exp_lat, input int hold);
        int lat;
        logic [W:0] exp;
        lat = 0;
        while (lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (bus.out_valid) break;
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        exp = exp_q.pop_front();
        check({tag, "_S"},    32'(bus.S),    32'(exp[W-1:0]));
        check({tag, "_Cout"}, 32'(bus.Cout), 32'(exp[W]));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
            check({tag, "_hold_S"},     32'(bus.S),         32'(exp[W-1:0]));
            check({tag, "_hold_Cout"},  32'(bus.Cout),      32'(exp[W]));
            check({tag, "_hold_ready"}, 32'(bus.in_ready),  32'd0);
            check({tag, "_hold_busy"},  32'(bus.busy),      32'd1);
            check({tag, "_hold_state"}, 32'(bus.fsm_state), 32'd2);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check({tag, "_post_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_post_ready"}, 32'(bus.in_ready),  32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.A         = '0;
        bus.B         = '0;
        bus.Cin       = 1'b0;
        bus.out_ready = 1'b0;
`ifdef SUB_EN
        bus.Sub       = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready",  32'(bus.in_ready),  32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_S",         32'(bus.S),         32'd0);
        check("rst_Cout",      32'(bus.Cout),      32'd0);
        check("rst_busy",      32'(bus.busy),      32'd0);
        rst = 1'b0;
        #1;
        check("rel_in_ready",  32'(bus.in_ready),  32'd1);

        // Basic add, latency 4.
        send(16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0);
        recv("add1", N, 0);

        // Carry ripples through every nibble.
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1);
        recv("ripple", N, 0);

        // Carry-in only; out_ready raised early (ignored outside DONE).
        bus.out_ready = 1'b1;
        send(16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0);
        recv("cin", N, 0);

        // Backpressure for 3 cycles in DONE.
        send(16'hABCD, 16'h1111, 1'b0, 1'b0, 16'hBCDE, 1'b0);
        recv("bp", N, 3);

        // Reset after two nibbles of RUN discards the operation.
        send(16'h5555, 16'h5555, 1'b0, 1'b0, 16'hAAAA, 1'b0);
        void'(exp_q.pop_back());
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("mrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("mrst_S",         32'(bus.S),         32'd0);
        check("mrst_Cout",      32'(bus.Cout),      32'd0);
        check("mrst_busy",      32'(bus.busy),      32'd0);
        check("mrst_in_ready",  32'(bus.in_ready),  32'd1);
        send(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0);
        recv("after_rst", N, 0);

        // in_valid held high with new operands during RUN must be ignored.
        bus.A        = 16'h1000;
        bus.B        = 16'h0234;
        bus.Cin      = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        exp_q.push_back({1'b0, 16'h1234});
        bus.A   = 16'hFFFF;
        bus.B   = 16'hFFFF;
        bus.Cin = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("run_in_ready", 32'(bus.in_ready), 32'd0);
        check("run_busy",     32'(bus.busy),     32'd1);
        bus.in_valid = 1'b0;
        recv("ignore_in", N - 2, 0);

        // Top-nibble carries.
        send(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1);
        recv("top_carry", N, 0);
        send(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1);
        recv("all_ones", N, 0);

`ifdef SUB_EN
        send(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0);
        recv("sub_borrow", N, 0);
        send(16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1);
        recv("sub_noborrow", N, 0);
`endif

        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/nibble_serial_adder_ctrl.md
# nibble_serial_adder_ctrl

Sequencing controller that performs wide (4·N_NIBBLES-bit) additions by time-multiplexing a single fourBitadder instance, one nibble per clock, least-significant first. It latches operands through a valid/ready input handshake, chains the ripple carry between nibbles in a register, and presents the full-width result through a valid/ready output handshake. It is the next step above the 4-bit adder: it reuses that datapath for wider words without replicating it.

## Interface
- N_NIBBLES, 4, operand width in nibbles (≥1); data width W = 4·N_NIBBLES
- clk  input  1  sole clock, rising edge
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  operands A, B, Cin valid
- in_ready  output  1  controller can accept operands
- A  input  W  operand A
- B  input  W  operand B
- Cin  input  1  carry into nibble 0
- out_valid  output  1  S, Cout hold a completed result
- out_ready  input  1  consumer accepts result
- S  output  W  sum
- Cout  output  1  carry out of the top nibble
- busy  output  1  high in RUN or DONE
- Sub  input  1  subtract select (only with SUB_EN)

## Operation
- One clock, clk; synchronous active-high reset rst. Internal: one fourBitadder; registers a_q, b_q, s_q (W bits), carry_q, idx (ceil(log2(N_NIBBLES)) bits, minimum 1), 2-bit state.
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready: latch A→a_q, B→b_q, Cin→carry_q, idx←0, s_q←0, go RUN. Otherwise hold.
- RUN: adder inputs are a_q[4·idx+:4], b_q[4·idx+:4], carry_q. Each cycle: s_q[4·idx+:4]←adder Sum, carry_q←adder Cout, idx←idx+1. When idx==N_NIBBLES-1, go DONE instead of incrementing (idx never wraps past the top nibble).
- DONE: out_valid=1. S=s_q, Cout=carry_q, both held stable until handshake. On out_ready: go IDLE.
- in_ready=0 in RUN and DONE; in_valid ignored there. No overlap: a new accept is possible only from IDLE, earliest one cycle after the output handshake.
- out_ready outside DONE is ignored.
- Arithmetic: {Cout,S} = A + B + Cin, modulo 2^(W+1); no saturation.
- Reset (any state, including mid-RUN): state←IDLE, in-flight operation discarded, s_q←0, carry_q←0, idx←0.
- Reset values: in_ready=0 while rst is high, 1 in the first cycle after release; out_valid=0, S=0, Cout=0, busy=0.

## Timing
- Accept edge = cycle 0. Nibble k is computed on edge k+1. out_valid rises after edge N_NIBBLES, so latency from accept to out_valid is N_NIBBLES cycles.
- Throughput with out_ready tied high: one result every N_NIBBLES+2 cycles (RUN ×N, DONE ×1, IDLE ×1).
- Output handshake completes on the edge where out_valid&&out_ready. in_ready is high on the following cycle.
- Combinational path is the adder only. All outputs are registered or decoded from state.

## Configuration
- SUB_EN defined: the Sub port exists and is latched with the operands.
  - When latched Sub=1: b_q is loaded as ~B and carry_q as 1; Cin is ignored.
  - Result is A−B mod 2^W. Cout=1 means no borrow (A≥B unsigned).
- SUB_EN undefined: no Sub port; add only.

## Test plan
- N=4, A=0x1234, B=0x0FFF, Cin=0 → out_valid exactly 4 cycles after accept, S=0x2233, Cout=0.
- A=0xFFFF, B=0x0001, Cin=0 → carry ripples through all nibbles: S=0x0000, Cout=1. Then A=0x00FF, B=0x0000, Cin=1 → S=0x0100, Cout=0.
- Backpressure: hold out_ready=0 for 3 cycles in DONE → S and Cout stable, in_ready=0, busy=1. Raise out_ready → out_valid=0 and in_ready=1 on the next cycle.
- Assert rst for 1 cycle after 2 nibbles in RUN → out_valid=0, S=0, in_ready=1 after release. Next op 0x0001+0x0001 → S=0x0002.
- in_valid held high during RUN with a different A → ignored; result reflects the originally latched operands.
- SUB_EN: A=0x0005, B=0x0007, Sub=1 → S=0xFFFE, Cout=0. A=0x0007, B=0x0005 → S=0x0002, Cout=1.
